// File: rtl/bp_be_stride_prefetch_issuer.sv
// rtl/bp_be_stride_prefetch_issuer.sv - turns confirmed load/store strides into a bounded stream of block-aligned D$ prefetches
// Each CALC cycle advances one stride; ISSUE holds the request until the D$ takes it.
module bp_be_stride_prefetch_issuer #(
    parameter int vaddr_width_p        = 39,
    parameter int dcache_block_width_p = 512,
    parameter int stride_width_p       = 8,
    parameter int degree_p             = 4,
    parameter int filter_els_p         = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_discovery_i,
    input  logic                      confirm_v_i,
    input  logic [vaddr_width_p-1:0]  pc_i,
    input  logic [vaddr_width_p-1:0]  base_addr_i,
    input  logic [stride_width_p-1:0] stride_i,
    input  logic                      flush_i,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_addr_o,
    input  logic                      pf_ready_i,
    output logic                      busy_o
);

    localparam int block_bytes_lp = dcache_block_width_p / 8;
    localparam int rem_w_lp       = $clog2(degree_p + 1);
    localparam int ptr_w_lp       = (filter_els_p > 1) ? $clog2(filter_els_p) : 1;
    localparam logic [vaddr_width_p-1:0] blk_mask_lp = vaddr_width_p'(block_bytes_lp - 1);

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_calc  = 2'd1,
        e_issue = 2'd2
    } state_e;

    state_e state_r, state_n;

    logic [vaddr_width_p-1:0]  pc_r;
    logic [vaddr_width_p-1:0]  cur_r;
    logic [stride_width_p-1:0] stride_r;
    logic [rem_w_lp-1:0]       remaining_r;
    logic [vaddr_width_p-1:0]  pf_addr_r;

    logic [filter_els_p-1:0]   filt_v_r;
    logic [vaddr_width_p-1:0]  filt_addr_r [filter_els_p];
    logic [ptr_w_lp-1:0]       wr_ptr_r;

    logic [vaddr_width_p-1:0]  stride_sext;
    logic [vaddr_width_p-1:0]  next_addr;
    logic [vaddr_width_p-1:0]  blk;
    logic [rem_w_lp-1:0]       rem_dec;
    logic                      filter_hit;
    logic                      handshake;
    logic                      new_stream;
    logic                      abort;

    assign stride_sext = {{(vaddr_width_p-stride_width_p){stride_r[stride_width_p-1]}}, stride_r};
    assign next_addr   = cur_r + stride_sext;
    assign blk         = next_addr & ~blk_mask_lp;
    assign rem_dec     = remaining_r - rem_w_lp'(1);

    assign handshake  = (state_r == e_issue) && pf_ready_i;
    assign new_stream = confirm_v_i && (stride_i != '0) && !flush_i;
    // A retrain of the entry we are streaming means the stride is no longer trusted.
    assign abort      = start_discovery_i && !confirm_v_i && !flush_i
                        && (state_r != e_idle) && (pc_i == pc_r);

    always_comb begin
        filter_hit = 1'b0;
        for (int i = 0; i < filter_els_p; i++) begin
            if (filt_v_r[i] && (filt_addr_r[i] == blk)) begin
                filter_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        if (flush_i) begin
            state_n = e_idle;
        end else if (new_stream) begin
            state_n = e_calc;
        end else if (abort) begin
            state_n = e_idle;
        end else begin
            case (state_r)
                e_idle: state_n = e_idle;
                e_calc: begin
                    if (!filter_hit) begin
                        state_n = e_issue;
                    end else if (rem_dec != '0) begin
                        state_n = e_calc;
                    end else begin
                        state_n = e_idle;
                    end
                end
                e_issue: begin
                    if (handshake) begin
                        state_n = (remaining_r != '0) ? e_calc : e_idle;
                    end
                end
                default: state_n = e_idle;
            endcase
        end
    end

    // Leaving ISSUE for any reason withdraws the request, so valid is purely a state decode.
    always_comb begin
        pf_v_o    = (state_r == e_issue);
        busy_o    = (state_r != e_idle);
        pf_addr_o = pf_addr_r;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_r        <= '0;
            cur_r       <= '0;
            stride_r    <= '0;
            remaining_r <= '0;
            pf_addr_r   <= '0;
            filt_v_r    <= '0;
            wr_ptr_r    <= '0;
            for (int i = 0; i < filter_els_p; i++) begin
                filt_addr_r[i] <= '0;
            end
        end else begin
            if (flush_i) begin
                filt_v_r <= '0;
                wr_ptr_r <= '0;
            end else if (handshake) begin
                filt_v_r[wr_ptr_r]    <= 1'b1;
                filt_addr_r[wr_ptr_r] <= pf_addr_r;
                wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(filter_els_p - 1)) ? '0 : wr_ptr_r + ptr_w_lp'(1);
            end

            if (new_stream) begin
                pc_r        <= pc_i;
                cur_r       <= base_addr_i;
                stride_r    <= stride_i;
                remaining_r <= rem_w_lp'(degree_p);
            end else if (!flush_i && !abort && (state_r == e_calc)) begin
                cur_r       <= next_addr;
                remaining_r <= rem_dec;
                if (!filter_hit) begin
                    pf_addr_r <= blk;
                end
            end
        end
    end

endmodule
